// File: rtl/dispenser_pkg.sv
// rtl/dispenser_pkg.sv - state encoding, 7-segment codes and BCD helper for dispenser_ctrl
package dispenser_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY      = 2'd0,
    ST_WARMING    = 2'd1,
    ST_HOT        = 2'd2,
    ST_DISPENSING = 2'd3
  } state_e;

  // Active-low abcdefg, segment a in the MSB
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Binary 0..99 to packed {tens, units} BCD
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 7'd10);
    units = 4'(v % 7'd10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// rtl/seg7_dec.sv - BCD digit to active-low 7-segment decoder
module seg7_dec
  import dispenser_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Codes above 9 are shown blank
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/dispenser_ctrl.sv
// rtl/dispenser_ctrl.sv - hot-water dispenser controller; IDLE_REHEAT_EN adds HOT idle reheat
module dispenser_ctrl
  import dispenser_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int LED_W      = 8,
  parameter int WARM_TICKS = 50,
  parameter int DISP_TICKS = 25,
  parameter int COOL_TICKS = 60
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fill,
  input  logic                         drain,
  input  logic                         dispense,
  output logic [$clog2(LED_W+1)-1:0]   level,
  output logic [1:0]                   state,
  output logic [LED_W-1:0]             led,
  output logic [6:0]                   digit4,
  output logic [6:0]                   digit3,
  output logic [6:0]                   digit2,
  output logic [6:0]                   digit1
);

  localparam int         LVL_W     = $clog2(LED_W + 1);
  localparam int         PW        = $clog2(CLK_DIV);
  localparam logic [6:0] WARM_LOAD = 7'(WARM_TICKS);
  localparam logic [6:0] DISP_LOAD = 7'(DISP_TICKS);

  if (CLK_DIV < 2 || WARM_TICKS < 1 || WARM_TICKS > 99 || DISP_TICKS < 1 ||
      DISP_TICKS > 99 || COOL_TICKS < 1 || COOL_TICKS > 99) begin : g_bad_params
    $error("dispenser_ctrl: parameter out of range");
  end

  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  state_e           state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [6:0]       warm_q, warm_d, disp_q, disp_d;
  logic             lock_q, lock_d;
  logic             fill_inc, idle_expire;
  logic [6:0]       timer;
  logic [7:0]       bcd;
  logic [6:0]       seg4, seg2, seg1;
  logic [LED_W-1:0] led_d, led_q;
  logic [6:0]       dig4_q, dig2_q, dig1_q;

  assign tick    = (presc_q == PW'(CLK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  // Free-running tick prescaler, untouched by the FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) presc_q <= '0;
    else      presc_q <= presc_d;
  end

  // A fill step only lands on a tick, outside DISPENSING, with no dispense request and room left
  assign fill_inc = tick && fill && !dispense && (state_q != ST_DISPENSING) &&
                    (level_q < LVL_W'(LED_W));

`ifdef IDLE_REHEAT_EN
  localparam logic [6:0] COOL_LOAD = 7'(COOL_TICKS);
  logic [6:0] idle_q, idle_d;

  assign idle_expire = (state_q == ST_HOT) && tick && (idle_q == 7'd1);

  // Idle countdown: reload on HOT entry or dispense grant, count ticks while HOT
  always_comb begin
    idle_d = idle_q;
    if (drain)
      idle_d = '0;
    else if ((state_d == ST_HOT && state_q != ST_HOT) ||
             (state_q == ST_HOT && state_d == ST_DISPENSING))
      idle_d = COOL_LOAD;
    else if (state_q == ST_HOT && tick)
      idle_d = idle_q - 7'd1;
  end

  // Idle counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_q <= '0;
    else      idle_q <= idle_d;
  end
`else
  assign idle_expire = 1'b0;
`endif

  // Next state, level and timers; drain beats dispense beats fill
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    warm_d  = warm_q;
    disp_d  = disp_q;
    lock_d  = lock_q && dispense;
    if (drain) begin
      state_d = ST_EMPTY;
      level_d = '0;
      warm_d  = '0;
      disp_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (fill_inc) begin
            level_d = level_q + LVL_W'(1);
            state_d = ST_WARMING;
            warm_d  = WARM_LOAD;
          end
        end
        ST_WARMING: begin
          if (fill_inc) begin
            level_d = level_q + LVL_W'(1);
            warm_d  = WARM_LOAD;
          end else if (tick) begin
            warm_d = warm_q - 7'd1;
            if (warm_q == 7'd1) state_d = ST_HOT;
          end
        end
        ST_HOT: begin
          if (dispense && level_q != '0 && !lock_q) begin
            state_d = ST_DISPENSING;
            disp_d  = DISP_LOAD;
          end else if (fill_inc) begin
            level_d = level_q + LVL_W'(1);
            state_d = ST_WARMING;
            warm_d  = WARM_LOAD;
          end else if (idle_expire) begin
            state_d = ST_WARMING;
            warm_d  = WARM_LOAD;
          end
        end
        default: begin
          if (!dispense) begin
            state_d = ST_HOT;
          end else if (tick) begin
            level_d = level_q - LVL_W'(1);
            disp_d  = disp_q - 7'd1;
            if (level_q == LVL_W'(1)) begin
              state_d = ST_EMPTY;
              disp_d  = '0;
            end else if (disp_q == 7'd1) begin
              state_d = ST_HOT;
              lock_d  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // FSM, level, timer and lockout registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      level_q <= '0;
      warm_q  <= '0;
      disp_q  <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      warm_q  <= warm_d;
      disp_q  <= disp_d;
      lock_q  <= lock_d;
    end
  end

  // Select the timer shown on the two right digits and build the thermometer bar
  always_comb begin
    timer = '0;
    case (state_q)
      ST_WARMING:    timer = warm_q;
      ST_DISPENSING: timer = disp_q;
`ifdef IDLE_REHEAT_EN
      ST_HOT:        timer = idle_q;
`endif
      default:       timer = '0;
    endcase
    for (int i = 0; i < LED_W; i++) led_d[i] = (int'(level_q) > i);
  end

  assign bcd = bin2bcd(timer);

  seg7_dec u_seg4 (.bcd_i({2'b00, state_q}), .seg_o(seg4));
  seg7_dec u_seg2 (.bcd_i(bcd[7:4]),         .seg_o(seg2));
  seg7_dec u_seg1 (.bcd_i(bcd[3:0]),         .seg_o(seg1));

  // Registered display outputs, one cycle behind the state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q  <= '0;
      dig4_q <= SEG_0;
      dig2_q <= SEG_0;
      dig1_q <= SEG_0;
    end else begin
      led_q  <= led_d;
      dig4_q <= seg4;
      dig2_q <= seg2;
      dig1_q <= seg1;
    end
  end

  assign level  = level_q;
  assign state  = state_q;
  assign led    = led_q;
  assign digit4 = dig4_q;
  assign digit3 = SEG_BLANK;
  assign digit2 = dig2_q;
  assign digit1 = dig1_q;

endmodule
